bram_1rw_arbiter: RTL
=====================

# bram_1rw_arbiter

Two-requester round-robin arbiter and sequencer for a single-port 1RW block RAM: one read or one write per cycle, registered read data one cycle after the access. It grants at most one request per cycle and drives the RAM's enable, write-enable, address and write-data pins. Read data is captured into a per-requester one-entry response buffer, so each requester sees a valid/ready response stream. It sits between two cache/fabric clients, e.g. fetch and load/store, and one shared data or tag RAM.

## Interface
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 64, RAM data width
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  request valid
- req_ready_0 / req_ready_1  out  1  request accepted when valid&ready
- req_write_0 / req_write_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_WIDTH  address
- req_wdata_0 / req_wdata_1  in  DATA_WIDTH  write data
- resp_valid_0 / resp_valid_1  out  1  read response valid
- resp_ready_0 / resp_ready_1  in  1  response consumed when valid&ready
- resp_rdata_0 / resp_rdata_1  out  DATA_WIDTH  read data
- ram_ena  out  1  RAM enable
- ram_wea  out  1  RAM write enable
- ram_addra  out  ADDR_WIDTH  RAM address
- ram_dina  out  DATA_WIDTH  RAM write data
- ram_douta  in  DATA_WIDTH  RAM registered read data, valid the cycle after a read access

## Operation
- State:
  - prio: 1 bit, the port favoured on conflict.
  - inflight: 1 bit, plus inflight_port, 1 bit.
  - Per port p: slot_valid_p, plus slot_data_p of DATA_WIDTH.
- Eligibility:
  - Port p is eligible iff req_valid_p and either req_write_p, or (no read in flight for p) and (slot_valid_p==0 or resp_ready_p==1 this cycle).
- Grant:
  - Only one eligible port: grant it.
  - Both eligible: grant port prio.
  - Neither eligible: no grant.
- After any grant, prio becomes the non-granted port. prio is unchanged on idle cycles.
- req_ready_p = grant_p, computed combinationally. Ready may depend on valid; requesters must not wait for ready before asserting valid.
- On grant: ram_ena=1, ram_wea=req_write_g, ram_addra=req_addr_g, ram_dina=req_wdata_g.
- No grant: ram_ena=0, ram_wea=0, addr and data driven 0.
- Granted read: at the clock edge, inflight←1 and inflight_port←g. Otherwise inflight←0.
- While inflight=1 with inflight_port=p, load slot_data_p←ram_douta and set slot_valid_p←1 at the clock edge.
- Slot load and consumption of the old entry at the same edge: the load wins and slot_valid stays 1. Eligibility guarantees the old entry is consumed at that edge.
- Writes produce no response. A write and a read to the same address from different ports are serialized in grant order: a read granted after the write returns the new data.
- resp_valid_p = slot_valid_p; resp_rdata_p = slot_data_p.

## Timing
- Reset (RST_N=0, asynchronous):
  - prio=0, inflight=0, inflight_port=0, slot_valid_0/1=0, slot_data=0.
  - All outputs 0 while reset is asserted, including req_ready and ram_ena.
- Read latency:
  - Accepted in cycle N.
  - RAM access in cycle N.
  - ram_douta valid in N+1, captured at the end of N+1.
  - resp_valid high from N+2.
- Write: accepted and performed in cycle N.
- Per-port read throughput is 1 per 2 cycles, because of the in-flight block. Alternating ports sustain 1 access per cycle.
- A response stalled by resp_ready=0 holds data and valid indefinitely. The port's reads stall but its writes continue.
- Reset mid-operation: in-flight read and buffered responses are discarded; no resp_valid after release.

## Test plan
- Single read: port0 reads addr 5 (previously written 0xDEAD) in cycle 0. Required: ram_ena=1, ram_wea=0 in cycle 0; resp_valid_0=1, rdata=0xDEAD in cycle 2; port1 idle.
- Conflict: both ports request in the same cycle after reset.
  - Port0 is granted first (prio=0), port1 the next cycle.
  - With both held valid, grants alternate 0,1,0,1.
- Backpressure: port1 reads with resp_ready_1=0.
  - resp_valid_1 stays high with data stable.
  - req_ready_1 stays 0 for a second read.
  - A write from port1 is still granted.
  - Raising resp_ready_1 allows a read grant in that same cycle.
- Same-address ordering: port0 writes 0x1234 to addr 3 in cycle 0; port1 reads addr 3 in cycle 1. Required: resp_rdata_1=0x1234 in cycle 3.
- Back-to-back throughput: 8 interleaved reads, both ports always ready. Required: ram_ena high 8 consecutive cycles, all 8 responses correct and in per-port order.
- Reset mid-read: assert RST_N=0 in the cycle after a read grant. Required: all outputs 0 immediately; after release, no resp_valid and prio=0.

Source files
------------

// File: rtl/bram_1rw_arbiter.sv
// bram_1rw_arbiter: two-port round-robin arbiter driving a single-port 1RW BRAM with per-port response slots
module bram_1rw_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_write_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  resp_valid_0,
    input  logic                  resp_ready_0,
    output logic [DATA_WIDTH-1:0] resp_rdata_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_write_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  resp_valid_1,
    input  logic                  resp_ready_1,
    output logic [DATA_WIDTH-1:0] resp_rdata_1,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);
    logic prio_q, prio_d;
    logic inflight_q, inflight_d;
    logic inflight_port_q, inflight_port_d;
    logic slot_valid_0_q, slot_valid_0_d, slot_valid_1_q, slot_valid_1_d;
    logic [DATA_WIDTH-1:0] slot_data_0_q, slot_data_0_d, slot_data_1_q, slot_data_1_d;
    logic elig_0, elig_1, grant_0, grant_1, load_0, load_1;

    // A read is eligible only if nothing is in flight for that port and its slot will be free at the edge
    always_comb begin
        elig_0 = req_valid_0 && (req_write_0 || (!(inflight_q && !inflight_port_q) && (!slot_valid_0_q || resp_ready_0)));
        elig_1 = req_valid_1 && (req_write_1 || (!(inflight_q && inflight_port_q) && (!slot_valid_1_q || resp_ready_1)));
        grant_0 = rst_n && elig_0 && (!elig_1 || !prio_q);
        grant_1 = rst_n && elig_1 && (!elig_0 || prio_q);
        ram_ena = grant_0 || grant_1;
        ram_wea = grant_0 ? req_write_0 : grant_1 ? req_write_1 : 1'b0;
        ram_addra = grant_0 ? req_addr_0 : grant_1 ? req_addr_1 : '0;
        ram_dina = grant_0 ? req_wdata_0 : grant_1 ? req_wdata_1 : '0;
    end

    // Next state: rotate priority, track the in-flight read, fill slots (a load beats a same-edge pop)
    always_comb begin
        prio_d = grant_0 ? 1'b1 : grant_1 ? 1'b0 : prio_q;
        inflight_d = ram_ena && !ram_wea;
        inflight_port_d = inflight_d ? grant_1 : inflight_port_q;
        load_0 = inflight_q && !inflight_port_q;
        load_1 = inflight_q && inflight_port_q;
        slot_valid_0_d = load_0 || (slot_valid_0_q && !resp_ready_0);
        slot_valid_1_d = load_1 || (slot_valid_1_q && !resp_ready_1);
        slot_data_0_d = load_0 ? ram_douta : slot_data_0_q;
        slot_data_1_d = load_1 ? ram_douta : slot_data_1_q;
    end

    // State registers, cleared asynchronously so reset discards in-flight reads and buffered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_port_q <= 1'b0;
            slot_valid_0_q  <= 1'b0;
            slot_valid_1_q  <= 1'b0;
            slot_data_0_q   <= '0;
            slot_data_1_q   <= '0;
        end else begin
            prio_q          <= prio_d;
            inflight_q      <= inflight_d;
            inflight_port_q <= inflight_port_d;
            slot_valid_0_q  <= slot_valid_0_d;
            slot_valid_1_q  <= slot_valid_1_d;
            slot_data_0_q   <= slot_data_0_d;
            slot_data_1_q   <= slot_data_1_d;
        end
    end

    assign req_ready_0  = grant_0;
    assign req_ready_1  = grant_1;
    assign resp_valid_0 = slot_valid_0_q;
    assign resp_valid_1 = slot_valid_1_q;
    assign resp_rdata_0 = slot_data_0_q;
    assign resp_rdata_1 = slot_data_1_q;
endmodule
